scan_timing_gen: RTL and testbench
==================================

// Module: scan_timing_gen
// PURPOSE
//  Parametrised successor of the 3D scan signal generator for the OCT slave driver.
//  Steps galvo X/Y waveform RAM addresses and drives both DA codes.
//  Generates N_TRIG independent per-point trigger channels (CCD line trigger, ACQ gate, spares).
//  Adds 2D, raster-3D, serpentine-3D and continuous modes, plus abort, replacing separate DA/ccd/acq generators.
// PARAMETERS
//  CNT_W   16  width of point, line, cycle and delay counts
//  ADDR_W  16  waveform RAM address width
//  DA_W    14  DA code width
//  N_TRIG  2   number of trigger channels (>=1)
// PORTS
//  sys_clk           in   1             single system clock, all logic rising-edge
//  sys_rst           in   1             asynchronous, active-high reset
//  start             in   1             1-cycle pulse; begins a scan when idle
//  abort             in   1             level/pulse; stops scan immediately
//  mode              in   2             0=2D, 1=3D raster, 2=3D serpentine, 3=continuous 3D raster
//  x_points          in   CNT_W         points per line (N_x)
//  y_points          in   CNT_W         lines per volume (N_y); ignored in mode 0
//  cycles_per_point  in   CNT_W         point period P in sys_clk cycles
//  da_delay_cycles   in   CNT_W         idle cycles between start and first point
//  trig_en           in   N_TRIG        per-channel enable
//  trig_delay        in   N_TRIG*CNT_W  channel k offset D_k within point, slice [k*CNT_W+:CNT_W]
//  trig_width        in   N_TRIG*CNT_W  channel k high time W_k, same slicing
//  x_data / y_data   in   DA_W each     waveform RAM read data, 1-cycle read latency
//  x_addr / y_addr   out  ADDR_W each   waveform RAM read address
//  da_x / da_y       out  DA_W each     DA codes to the converter
//  trig              out  N_TRIG        trigger outputs
//  line_start        out  1             1-cycle pulse at phase 0 of each line's first point
//  busy              out  1             high in DELAY or RUN
//  done              out  1             1-cycle pulse at normal completion
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (addresses, DA codes, trig, line_start, busy, done).
//  Configuration (mode, counts, delays, widths, trig_en) is latched on the accepted start.
//  Later input changes do not affect a running scan.
//  P<2 is latched as 2.
//  FSM: IDLE -start-> DELAY (counts da_delay_cycles; 0 = skip) -> RUN -last point end-> DONE (1 cycle) -> IDLE.
//  start while busy is ignored.
//  start with N_x=0, or N_y=0 in modes 1-3: IDLE->DONE directly, no RUN, no trig.
//  RUN: phase counter ph runs 0..P-1 per point; point index x; line index y.
//  x_addr/y_addr update at ph=0.
//  da_x/da_y load x_data/y_data at ph=1 and hold until the next load.
//  Point order at end of point (ph=P-1):
//   - If x<N_x-1: x++.
//   - Otherwise: x=0 and y++.
//   - At y=N_y-1 the scan ends, except mode 3 wraps y=0 and runs until abort.
//  Mode 0: single line; y_addr=0; done after N_x points.
//  Mode 2: x_addr = x on even y and N_x-1-x on odd y.
//  trig[k] = trig_en[k] && RUN && D_k <= ph < D_k+W_k.
//   - Compare in CNT_W+1 bits, no overflow.
//   - Pulses never span a point boundary; they are truncated at ph=P-1.
//  D_k>=P or W_k=0: channel k stays low.
//  Registered output: trig[k] rises one cycle after the ph=D_k cycle.
//  Abort (any state): next cycle FSM=IDLE, busy=0, trig=0, line_start=0, no done.
//   - da_x/da_y and addresses hold their last values.
//  abort and start in the same cycle: abort wins; start is dropped.
//  sys_rst during RUN: immediate return to reset values.
// TESTING
//  - Mode 1, N_x=4, N_y=3, P=5, delay=2, D0=1, W0=2 -> 12 points of 5 cycles.
//    trig[0] is 2 cycles wide per point; done 1 cycle after the 60th RUN cycle; busy 62 cycles.
//  - Mode 2, N_x=3, N_y=2 -> x_addr sequence 0,1,2,2,1,0; y_addr 0,0,0,1,1,1; line_start twice.
//  - P=4, D1=3, W1=5 -> trig[1] high 1 cycle per point.
//    D1=4 -> trig[1] never high; trig_en[1]=0 -> never high.
//  - Mode 3, N_x=2, N_y=2 for 3 volumes -> y wraps 1->0, no done.
//    abort mid-point -> trig=0 and busy=0 next cycle; da_x holds.
//  - N_x=0 with start -> done pulse 1 cycle later, busy never high.
//    start during RUN -> ignored, sequence unchanged.
//  - sys_rst asserted asynchronously mid-RUN -> all outputs 0 without a clock edge.
//    Restart after release -> sequence from x=0, y=0.

Source files
------------

// File: rtl/scan_timing_gen.sv
// OCT scan timing generator: steps galvo X/Y waveform RAM addresses, loads DA codes
// and produces per-point trigger channels for 2D, raster/serpentine 3D and continuous scans.
module scan_timing_gen #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16,
  parameter int DA_W   = 14,
  parameter int N_TRIG = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        x_points,
  input  logic [CNT_W-1:0]        y_points,
  input  logic [CNT_W-1:0]        cycles_per_point,
  input  logic [CNT_W-1:0]        da_delay_cycles,
  input  logic [N_TRIG-1:0]       trig_en,
  input  logic [N_TRIG*CNT_W-1:0] trig_delay,
  input  logic [N_TRIG*CNT_W-1:0] trig_width,
  input  logic [DA_W-1:0]         x_data,
  input  logic [DA_W-1:0]         y_data,
  output logic [ADDR_W-1:0]       x_addr,
  output logic [ADDR_W-1:0]       y_addr,
  output logic [DA_W-1:0]         da_x,
  output logic [DA_W-1:0]         da_y,
  output logic [N_TRIG-1:0]       trig,
  output logic                    line_start,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t                  state;
  logic [1:0]              cfg_mode;
  logic [CNT_W-1:0]        cfg_nx, cfg_ny, cfg_p;
  logic [N_TRIG-1:0]       cfg_en;
  logic [N_TRIG*CNT_W-1:0] cfg_d, cfg_w;
  logic [CNT_W-1:0]        dcnt, ph, xi, yi;

  logic [CNT_W-1:0]        nxt_x, nxt_y;
  logic [ADDR_W-1:0]       nxt_xa;
  logic                    scan_end;
  logic                    cfg_empty;
  logic [CNT_W-1:0]        p_eff;
  logic [N_TRIG-1:0]       trig_hit;

  always_comb begin
    p_eff     = (cycles_per_point < TWO) ? TWO : cycles_per_point;
    cfg_empty = (x_points == '0) || ((mode != 2'd0) && (y_points == '0));
  end

  // Next point in scan order; mode 0 never advances y, mode 3 wraps y instead of ending.
  always_comb begin
    nxt_x    = xi + ONE;
    nxt_y    = yi;
    scan_end = 1'b0;
    if (xi >= cfg_nx - ONE) begin
      nxt_x = '0;
      if ((cfg_mode == 2'd0) || (yi == cfg_ny - ONE)) begin
        nxt_y    = '0;
        scan_end = (cfg_mode != 2'd3);
      end else begin
        nxt_y = yi + ONE;
      end
    end
    if ((cfg_mode == 2'd2) && nxt_y[0])
      nxt_xa = ADDR_W'(cfg_nx - ONE - nxt_x);
    else
      nxt_xa = ADDR_W'(nxt_x);
  end

  // Window compare is one bit wider so D+W cannot wrap around.
  for (genvar k = 0; k < N_TRIG; k++) begin : g_trig
    logic [CNT_W:0] win_lo, win_hi;
    always_comb begin
      win_lo      = {1'b0, cfg_d[k*CNT_W +: CNT_W]};
      win_hi      = win_lo + {1'b0, cfg_w[k*CNT_W +: CNT_W]};
      trig_hit[k] = cfg_en[k] && ({1'b0, ph} >= win_lo) && ({1'b0, ph} < win_hi);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cfg_mode   <= '0;
      cfg_nx     <= '0;
      cfg_ny     <= '0;
      cfg_p      <= '0;
      cfg_en     <= '0;
      cfg_d      <= '0;
      cfg_w      <= '0;
      dcnt       <= '0;
      ph         <= '0;
      xi         <= '0;
      yi         <= '0;
      x_addr     <= '0;
      y_addr     <= '0;
      da_x       <= '0;
      da_y       <= '0;
      trig       <= '0;
      line_start <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      trig       <= '0;
      line_start <= 1'b0;
    end else begin
      line_start <= 1'b0;
      trig       <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_mode <= mode;
            cfg_nx   <= x_points;
            cfg_ny   <= y_points;
            cfg_p    <= p_eff;
            cfg_en   <= trig_en;
            cfg_d    <= trig_delay;
            cfg_w    <= trig_width;
            ph       <= '0;
            xi       <= '0;
            yi       <= '0;
            if (cfg_empty) begin
              state <= S_DONE;
            end else if (da_delay_cycles == '0) begin
              state      <= S_RUN;
              x_addr     <= '0;
              y_addr     <= '0;
              line_start <= 1'b1;
            end else begin
              state <= S_DELAY;
              dcnt  <= da_delay_cycles;
            end
          end
        end
        S_DELAY: begin
          if (dcnt == ONE) begin
            state      <= S_RUN;
            x_addr     <= '0;
            y_addr     <= '0;
            line_start <= 1'b1;
          end else begin
            dcnt <= dcnt - ONE;
          end
        end
        S_RUN: begin
          trig <= trig_hit;
          if (ph == ONE) begin
            da_x <= x_data;
            da_y <= y_data;
          end
          if (ph == cfg_p - ONE) begin
            ph <= '0;
            if (scan_end) begin
              state <= S_DONE;
            end else begin
              xi         <= nxt_x;
              yi         <= nxt_y;
              x_addr     <= nxt_xa;
              y_addr     <= ADDR_W'(nxt_y);
              line_start <= (nxt_x == '0);
            end
          end else begin
            ph <= ph + ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_DELAY) || (state == S_RUN);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_scan_timing_gen.sv
// Scoreboard bench for scan_timing_gen: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares one record per cycle.
module tb_scan_timing_gen;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 16;
  localparam int DA_W   = 14;
  localparam int N_TRIG = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = '0;
  logic [CNT_W-1:0] x_points = '0, y_points = '0, cycles_per_point = '0, da_delay_cycles = '0;
  logic [N_TRIG-1:0] trig_en = '0;
  logic [N_TRIG*CNT_W-1:0] trig_delay = '0, trig_width = '0;
  logic [DA_W-1:0] x_data, y_data;
  logic [ADDR_W-1:0] x_addr, y_addr;
  logic [DA_W-1:0] da_x, da_y;
  logic [N_TRIG-1:0] trig;
  logic line_start, busy, done;

  scan_timing_gen #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DA_W(DA_W), .N_TRIG(N_TRIG)) dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .abort(abort), .mode(mode),
    .x_points(x_points), .y_points(y_points), .cycles_per_point(cycles_per_point),
    .da_delay_cycles(da_delay_cycles), .trig_en(trig_en), .trig_delay(trig_delay),
    .trig_width(trig_width), .x_data(x_data), .y_data(y_data), .x_addr(x_addr),
    .y_addr(y_addr), .da_x(da_x), .da_y(da_y), .trig(trig), .line_start(line_start),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DA_W-1:0] fx(input logic [ADDR_W-1:0] a);
    return a[DA_W-1:0] ^ 14'h2A5;
  endfunction
  function automatic logic [DA_W-1:0] fy(input logic [ADDR_W-1:0] a);
    return a[DA_W-1:0] ^ 14'h1C3;
  endfunction

  // waveform RAM with 1-cycle read latency
  always @(posedge clk) begin
    x_data <= fx(x_addr);
    y_data <= fy(y_addr);
  end

  typedef struct packed {
    logic busy, done, ls;
    logic [1:0] trig;
    logic [15:0] xa, ya;
    logic [13:0] dx, dy;
  } obs_t;
  typedef struct {
    int   tag;
    int   idx;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  logic [15:0] m_xa = '0, m_ya = '0;
  logic [13:0] m_dx = '0, m_dy = '0;
  logic [1:0]  m_tq = '0;
  int          m_n = 0;

  exp_t mon_e;
  obs_t mon_a;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      mon_a = {busy, done, line_start, trig, x_addr, y_addr, da_x, da_y};
      checks++;
      if (mon_a !== mon_e.o) begin
        failures++;
        $display("FAIL cycle test=%0d idx=%0d actual busy=%b done=%b ls=%b trig=%b xa=%0d ya=%0d dx=%h dy=%h required busy=%b done=%b ls=%b trig=%b xa=%0d ya=%0d dx=%h dy=%h",
                 mon_e.tag, mon_e.idx, mon_a.busy, mon_a.done, mon_a.ls, mon_a.trig, mon_a.xa,
                 mon_a.ya, mon_a.dx, mon_a.dy, mon_e.o.busy, mon_e.o.done, mon_e.o.ls,
                 mon_e.o.trig, mon_e.o.xa, mon_e.o.ya, mon_e.o.dx, mon_e.o.dy);
      end
    end
  end

  task automatic emit(input int tag, input logic b, input logic d, input logic l);
    exp_t e;
    e.tag = tag;
    e.idx = m_n;
    e.o   = {b, d, l, m_tq, m_xa, m_ya, m_dx, m_dy};
    q.push_back(e);
    m_n++;
  endtask

  task automatic push_scan(input int tag, input int md, input int nx, input int ny, input int p,
                           input int dly, input logic [1:0] en, input int d0, input int w0,
                           input int d1, input int w1, input int stop_at, input bit do_abort);
    int pe, xi, yi;
    bit fin, stopped;
    logic [1:0] tn;
    m_n = 0;
    pe = (p < 2) ? 2 : p;
    if (nx == 0 || (md != 0 && ny == 0)) begin
      emit(tag, 1'b0, 1'b1, 1'b0);
      emit(tag, 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int i = 0; i < dly; i++) emit(tag, 1'b1, 1'b0, 1'b0);
    xi = 0; yi = 0; fin = 0; stopped = 0;
    while (!fin && !stopped) begin
      for (int ph = 0; ph < pe; ph++) begin
        if (ph == 0) begin
          m_xa = ADDR_W'((md == 2 && (yi % 2) == 1) ? (nx - 1 - xi) : xi);
          m_ya = ADDR_W'(yi);
        end
        emit(tag, 1'b1, 1'b0, (ph == 0 && xi == 0));
        if (stop_at >= 0 && m_n >= stop_at) begin
          stopped = 1;
          break;
        end
        tn[0] = en[0] && (d0 <= ph) && (ph < d0 + w0);
        tn[1] = en[1] && (d1 <= ph) && (ph < d1 + w1);
        m_tq = tn;
        if (ph == 1) begin
          m_dx = fx(m_xa);
          m_dy = fy(m_ya);
        end
      end
      if (!stopped) begin
        if (xi < nx - 1) xi++;
        else begin
          xi = 0;
          if (md == 0 || yi == ny - 1) begin
            if (md == 3) yi = 0;
            else fin = 1;
          end else yi++;
        end
      end
    end
    if (stopped) begin
      if (do_abort) begin
        m_tq = '0;
        emit(tag, 1'b0, 1'b0, 1'b0);
        emit(tag, 1'b0, 1'b0, 1'b0);
      end
    end else begin
      emit(tag, 1'b0, 1'b1, 1'b0);
      m_tq = '0;
      emit(tag, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_start(input int md, input int nx, input int ny, input int p, input int dly,
                          input logic [1:0] en, input int d0, input int w0, input int d1,
                          input int w1);
    mode             = 2'(md);
    x_points         = CNT_W'(nx);
    y_points         = CNT_W'(ny);
    cycles_per_point = CNT_W'(p);
    da_delay_cycles  = CNT_W'(dly);
    trig_en          = en;
    trig_delay       = {CNT_W'(d1), CNT_W'(d0)};
    trig_width       = {CNT_W'(w1), CNT_W'(w0)};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain timeout remaining=%0d required=0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_xa = '0; m_ya = '0; m_dx = '0; m_dy = '0; m_tq = '0;
  endtask

  initial begin
    // reset state
    for (int i = 0; i < 3; i++) emit(0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    drain();

    // raster 3D with start pulse and input changes mid-scan
    do_start(1, 4, 3, 5, 2, 2'b01, 1, 2, 0, 0);
    push_scan(1, 1, 4, 3, 5, 2, 2'b01, 1, 2, 0, 0, -1, 1'b0);
    repeat (20) @(posedge clk);
    #1 x_points = 16'd7; cycles_per_point = 16'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    // serpentine
    do_start(2, 3, 2, 3, 0, 2'b11, 0, 1, 2, 1);
    push_scan(2, 2, 3, 2, 3, 0, 2'b11, 0, 1, 2, 1, -1, 1'b0);
    drain();

    // window truncated at point end, one-cycle trig[1]
    do_start(0, 3, 9, 4, 1, 2'b11, 0, 1, 3, 5);
    push_scan(3, 0, 3, 9, 4, 1, 2'b11, 0, 1, 3, 5, -1, 1'b0);
    drain();

    // D1=P never fires; D0+W0 beyond CNT_W must not wrap
    do_start(0, 2, 0, 4, 0, 2'b11, 2, 65535, 4, 3);
    push_scan(4, 0, 2, 0, 4, 0, 2'b11, 2, 65535, 4, 3, -1, 1'b0);
    drain();

    // channel disabled, W0=0, P<2 latched as 2
    do_start(1, 2, 1, 0, 0, 2'b01, 1, 0, 0, 2);
    push_scan(5, 1, 2, 1, 0, 0, 2'b01, 1, 0, 0, 2, -1, 1'b0);
    drain();

    // continuous mode, three volumes then abort at ph=1
    do_start(3, 2, 2, 3, 0, 2'b01, 0, 2, 0, 0);
    push_scan(6, 3, 2, 2, 3, 0, 2'b01, 0, 2, 0, 0, 38, 1'b1);
    repeat (37) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    drain();

    // empty configurations
    do_start(1, 0, 3, 4, 2, 2'b01, 0, 1, 0, 0);
    push_scan(7, 1, 0, 3, 4, 2, 2'b01, 0, 1, 0, 0, -1, 1'b0);
    drain();
    do_start(2, 3, 0, 4, 0, 2'b01, 0, 1, 0, 0);
    push_scan(8, 2, 3, 0, 4, 0, 2'b01, 0, 1, 0, 0, -1, 1'b0);
    drain();

    // abort and start together: start dropped
    x_points = 16'd2; y_points = 16'd2; mode = 2'd1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; start = 1'b0;
    m_n = 0;
    emit(9, 1'b0, 1'b0, 1'b0);
    emit(9, 1'b0, 1'b0, 1'b0);
    drain();

    // asynchronous reset mid-run, then restart from origin
    do_start(1, 2, 2, 3, 1, 2'b01, 1, 1, 0, 0);
    push_scan(10, 1, 2, 2, 3, 1, 2'b01, 1, 1, 0, 0, 5, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) emit(11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drain();
    do_start(1, 2, 2, 3, 1, 2'b01, 1, 1, 0, 0);
    push_scan(12, 1, 2, 2, 3, 1, 2'b01, 1, 1, 0, 0, -1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
